// File: rtl/sprite_rom_writer.sv
// Packs a raster stream of 3-bit RGB pixels into 16-bit words (4 pixels each) and writes one sprite slot.
// Optional running word checksum is enabled by defining SPRITE_WRITER_CHECKSUM_EN.
module sprite_rom_writer #(
    parameter int unsigned NUM_SPRITES = 7,
    parameter int unsigned SPRITE_DIM  = 64,
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned ADDR_WIDTH  = 13
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [2:0]            sprite_idx,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [2:0]            pix_rgb,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           checksum
);

    localparam int unsigned      PIX_W    = $clog2(SPRITE_DIM * SPRITE_DIM);
    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(SPRITE_DIM * SPRITE_DIM - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [PIX_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   pack_q, pack_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    err_q, err_d;
    logic                    idx_ok;
    logic                    start_ok;

    assign idx_ok   = 32'(sprite_idx) < NUM_SPRITES;
    assign start_ok = (state_q == IDLE) && start && idx_ok;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            pack_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            pack_q  <= pack_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        pack_d  = pack_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (idx_ok) begin
                        idx_d   = sprite_idx;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (pix_valid) begin
                    // Slot k occupies bits [4k+3:4k]; the low bit of each nibble stays 0.
                    pack_d[{cnt_q[1:0], 2'b00} +: 4] = {pix_rgb, 1'b0};
                    if (cnt_q[1:0] == 2'b11) begin
                        we_d    = 1'b1;
                        waddr_d = ADDR_WIDTH'({idx_q, cnt_q[PIX_W-1:2]});
                        wdata_d = pack_d;
                    end
                    if (cnt_q == LAST_PIX) begin
                        state_d = FLUSH;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FLUSH:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign pix_ready = (state_q == LOAD);
    assign busy      = (state_q == LOAD) || (state_q == FLUSH);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign mem_we    = we_q;
    assign mem_waddr = waddr_q;
    assign mem_wdata = wdata_q;

`ifdef SPRITE_WRITER_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    // Summed from the registered strobe, so the final word lands in the done cycle.
    always_comb begin
        csum_d = csum_q;
        if (start_ok) begin
            csum_d = '0;
        end else if (we_q) begin
            csum_d = csum_q + 16'(wdata_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign checksum = csum_q;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_sprite_rom_writer.sv
// Directed bench for sprite_rom_writer with a write scoreboard; define SPRITE_WRITER_CHECKSUM_EN to check the checksum.
module tb_sprite_rom_writer;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [2:0]  sprite_idx;
    logic        pix_valid;
    logic        pix_ready;
    logic [2:0]  pix_rgb;
    logic        mem_we;
    logic [12:0] mem_waddr;
    logic [15:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] checksum;

    int unsigned checks  = 0;
    int unsigned errors  = 0;
    int unsigned strobes = 0;
    int unsigned done_cnt = 0;
    int unsigned err_cnt  = 0;
    logic [15:0] exp_sum;
    logic [28:0] exp_q[$];

    sprite_rom_writer #(
        .NUM_SPRITES(7),
        .SPRITE_DIM (64),
        .DATA_WIDTH (16),
        .ADDR_WIDTH (13)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sprite_idx(sprite_idx),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_rgb   (pix_rgb),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .checksum  (checksum)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the oldest expected word.
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err)  err_cnt++;
        if (mem_we) begin
            logic [28:0] e;
            strobes++;
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL unexpected_write: observed addr %0d expected no write", mem_waddr);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("waddr", 32'(mem_waddr), 32'(e[28:16]));
                chk("wdata", 32'(mem_wdata), 32'(e[15:0]));
            end
        end
    end

    function automatic logic [2:0] pix_val(input int unsigned mode, input int unsigned n);
        case (mode)
            0:       return 3'd7;
            1:       return 3'((n % 4) + 1);
            default: return 3'((n ^ (n >> 3) ^ (n >> 7)) & 7);
        endcase
    endfunction

    task automatic run_load(input logic [2:0] idx, input int unsigned mode, input bit gaps,
                            input int unsigned npix, input bit poke);
        logic [15:0] word;
        logic [2:0]  rgb;
        logic        xfer;
        int unsigned n;
        int unsigned stall;
        strobes = 0;
        exp_sum = '0;
        word    = '0;
        @(posedge clk); #1;
        start      = 1'b1;
        sprite_idx = idx;
        @(posedge clk); #1;
        start      = 1'b0;
        sprite_idx = 3'd1;
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("ready_after_start", 32'(pix_ready), 32'd1);
        n = 0;
        stall = 0;
        while (n < npix) begin
            rgb       = pix_val(mode, n);
            pix_rgb   = rgb;
            pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            if (poke && n == 100) begin
                start      = 1'b1;
                sprite_idx = 3'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            xfer = pix_valid && pix_ready;
            @(posedge clk); #1;
            if (xfer) begin
                word[4*(n%4) +: 4] = {rgb, 1'b0};
                if (n % 4 == 3) begin
                    exp_q.push_back({13'(32'(idx) * 1024 + n / 4), word});
                    exp_sum = exp_sum + word;
                end
                n++;
                stall = 0;
            end else begin
                stall++;
                if (stall > 40) begin
                    chk("pix_ready_timeout", 32'(pix_ready), 32'd1);
                    break;
                end
            end
        end
        pix_valid = 1'b0;
        start     = 1'b0;
        if (npix == 4096) begin
            chk("flush_busy", 32'(busy), 32'd1);
            chk("flush_done", 32'(done), 32'd0);
            @(posedge clk); #1;
            chk("done_pulse", 32'(done), 32'd1);
            chk("done_busy", 32'(busy), 32'd0);
`ifdef SPRITE_WRITER_CHECKSUM_EN
            chk("checksum", 32'(checksum), 32'(exp_sum));
`else
            chk("checksum_off", 32'(checksum), 32'd0);
`endif
            @(posedge clk); #1;
            chk("done_cleared", 32'(done), 32'd0);
            chk("strobe_count", strobes, 32'd1024);
            chk("queue_drained", exp_q.size(), 32'd0);
            chk("waddr_hold", 32'(mem_waddr), 32'(idx) * 1024 + 1023);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 32'(pix_ready), 32'd0);
        chk({tag, "_we"},    32'(mem_we),    32'd0);
        chk({tag, "_waddr"}, 32'(mem_waddr), 32'd0);
        chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_busy"},  32'(busy),      32'd0);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_err"},   32'(err),       32'd0);
        chk({tag, "_csum"},  32'(checksum),  32'd0);
    endtask

    initial begin
        int unsigned dsave;
        reset_n    = 1'b1;
        start      = 1'b0;
        sprite_idx = 3'd0;
        pix_valid  = 1'b0;
        pix_rgb    = 3'd0;
        #1 reset_n = 1'b0;
        #2;
        chk_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;

        // Slot 0, all white, no gaps.
        run_load(3'd0, 0, 1'b0, 4096, 1'b0);

        // Slot 6, pixels cycling 1..4 -> every word 16'h8642.
        run_load(3'd6, 1, 1'b0, 4096, 1'b0);
        chk("last_word_data", 32'(mem_wdata), 32'h8642);
`ifdef SPRITE_WRITER_CHECKSUM_EN
        chk("checksum_0800", 32'(checksum), 32'h0800);
`endif

        // Invalid slot.
        strobes = 0;
        err_cnt = 0;
        @(posedge clk); #1;
        start      = 1'b1;
        sprite_idx = 3'd7;
        @(posedge clk); #1;
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_busy", 32'(busy), 32'd0);
        chk("err_ready", 32'(pix_ready), 32'd0);
        @(posedge clk); #1;
        chk("err_cleared", 32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("err_no_writes", strobes, 32'd0);
        chk("err_count", err_cnt, 32'd1);

        // Slot 2 with random valid gaps.
        run_load(3'd2, 2, 1'b1, 4096, 1'b0);

        // Slot 3 with a stray start at pixel 100.
        err_cnt = 0;
        run_load(3'd3, 2, 1'b0, 4096, 1'b1);
        chk("stray_start_no_err", err_cnt, 32'd0);

        // Slot 4 aborted by reset after 2000 pixels, then reloaded.
        dsave = done_cnt;
        run_load(3'd4, 1, 1'b0, 2000, 1'b0);
        @(negedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk_all_zero("abort");
        chk("abort_writes", strobes, 32'd500);
        chk("abort_queue", exp_q.size(), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt, dsave);
        chk("abort_idle_busy", 32'(busy), 32'd0);
        run_load(3'd4, 1, 1'b0, 4096, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_rom_writer.md
Name: sprite_rom_writer

Overview:
- Write-side counterpart of the sprite ROM reader: accepts a raster stream of 3-bit RGB pixels for one 64x64 sprite from the MCU link and packs 4 pixels per 16-bit word.
- Issues single-cycle write strobes into the shared 7-sprite, 7168-word sprite memory.
- Uses the same packing and address map the read path decodes, so any sprite slot can be reloaded at runtime.

Parameters:
- NUM_SPRITES, 7, number of sprite slots; valid sprite_idx range is 0..NUM_SPRITES-1.
- SPRITE_DIM, 64, sprite width and height in pixels.
- DATA_WIDTH, 16, memory word width; holds 4 pixels.
- ADDR_WIDTH, 13, memory word address width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin loading a sprite.
- sprite_idx  in  3  target slot; sampled when start is accepted.
- pix_valid  in  1  pix_rgb carries a valid pixel.
- pix_ready  out  1  block accepts a pixel this cycle.
- pix_rgb  in  3  pixel colour {R,G,B}.
- mem_we  out  1  write strobe to sprite memory.
- mem_waddr  out  ADDR_WIDTH  word address.
- mem_wdata  out  DATA_WIDTH  packed word.
- busy  out  1  high while a load is in progress.
- done  out  1  one-cycle pulse after the final word is written.
- err  out  1  one-cycle pulse when start names an invalid slot.
- checksum  out  16  word checksum; see Optional Feature.

Behaviour:
- Reset (reset_n=0, asynchronous): every output is 0, state=IDLE, counters and pack register cleared.
- Reset mid-load aborts the load immediately. Words already written stay in memory, and no done pulse is issued.
- Handshake: a pixel transfers on any cycle where pix_valid=1 and pix_ready=1. pix_ready is 1 exactly when state=LOAD, with no further backpressure.
- Pixel order is raster: pixel n = y*64+x, for n = 0..4095.
- Packing: pixel n goes to word w = n>>2, slot k = n[1:0]. Bits [4k+3:4k+1] hold {R,G,B}; bit 4k is 0.
- Address: mem_waddr = sprite_idx*1024 + w, i.e. {sprite_idx, w[9:0]}.
- Write timing:
  - When pixel with k=3 is accepted at cycle t, mem_we=1 at cycle t+1 with the complete word and its address.
  - mem_we is high for exactly one cycle per word, 1024 strobes per sprite.
  - mem_wdata and mem_waddr hold their last values when mem_we=0.
- State IDLE:
  - start=1 with sprite_idx<NUM_SPRITES: latch sprite_idx, clear pixel counter, go to LOAD, busy=1 next cycle.
  - start=1 with sprite_idx>=NUM_SPRITES: err=1 next cycle, remain in IDLE.
- State LOAD:
  - Accept pixels and increment the 12-bit pixel counter on each transfer.
  - On acceptance of pixel 4095, go to FLUSH.
- State FLUSH (one cycle): last word is written (mem_we=1, address sprite_idx*1024+1023). Go to DONE.
- State DONE (one cycle): done=1, busy drops to 0 on the same cycle, return to IDLE.
- Latency: start to first pix_ready is 1 cycle. Last pixel to done is 2 cycles.
- start while busy=1 is ignored, with no err.
- pix_valid outside LOAD is ignored, with no transfer.
- Pixel counter does not wrap past 4095; the transition to FLUSH guarantees this.
- Partial words never occur in a completed load.

Optional Feature:
- Macro: SPRITE_WRITER_CHECKSUM_EN.
- With the macro defined:
  - checksum is the 16-bit modular sum of every mem_wdata written in the current load.
  - Cleared on accepted start; stable and valid from the done cycle until the next accepted start.
- Without the macro: checksum is constant 0, and no adder or register is synthesized.

Test Plan:
- Reset then start, sprite_idx=0, 4096 pixels all 3'b111 with pix_valid held high:
  - 1024 mem_we pulses at addresses 0..1023, each mem_wdata=16'hEEEE.
  - done 2 cycles after the last pixel.
- sprite_idx=6, pixel values cycling 1,2,3,4:
  - first write at mem_waddr=6144 with mem_wdata=16'h8642.
  - last write at 7167.
  - with CHECKSUM_EN, checksum = 1024*16'h8642 mod 2^16 = 16'h0800.
- start with sprite_idx=7: err pulses 1 cycle, busy stays 0, no mem_we.
- Random pix_valid gaps (about 50% duty) with sprite_idx=2:
  - write addresses and data identical to the gap-free run.
  - exactly 1024 strobes.
- start pulsed again at pixel 100 of a load: ignored, load completes normally.
- reset_n asserted after pixel 2000:
  - all outputs 0 at once, no done.
  - a fresh load to the same slot then completes with 1024 writes.
